// File: rtl/flash_host_bridge_if.sv
// CPU-side byte bus between the host and flash_host_bridge.
// master: CPU side, drives requests. slave: bridge side, returns ready/rdata.
interface flash_host_bridge_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata
  );
endinterface

// File: rtl/flash_host_bridge.sv
// Host bus slave in front of flash_ctl. Writes are posted into a small FIFO and
// drained one at a time; reads are blocking with a single outstanding request.
// Optional feature macro: READ_CACHE_EN adds a one-entry read cache.
module flash_host_bridge #(
  parameter int unsigned WBUF_AW = 2,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  flash_host_bridge_if.slave cpu,
  output logic               o_fl_read,
  output logic               o_fl_write,
  output logic [ADDR_W-1:0]  o_fl_addr,
  output logic [7:0]         o_fl_din,
  input  logic [7:0]         i_fl_dout,
  input  logic               i_fl_busy
);
  localparam int unsigned Depth = 2 ** WBUF_AW;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

  state_e              r_state, w_state_next;
  logic [WBUF_AW:0]    r_wr_ptr, r_rd_ptr;
  logic [ADDR_W-1:0]   r_wbuf_addr [Depth];
  logic [7:0]          r_wbuf_data [Depth];
  logic                r_rd_pend;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_fl_addr;
  logic [7:0]          r_fl_din;
  logic                r_rvalid;
  logic [7:0]          r_rdata;

  logic w_full, w_empty, w_rd_ok, w_push, w_rd_acc, w_pop, w_start_rd, w_done;
  logic w_hit;
  logic [7:0] w_hit_data;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[WBUF_AW] != r_rd_ptr[WBUF_AW]) &&
                   (r_wr_ptr[WBUF_AW-1:0] == r_rd_ptr[WBUF_AW-1:0]);

  // Reads wait for all posted writes to land, which gives read-after-write ordering.
  assign w_rd_ok       = w_empty && (r_state == StIdle) && !r_rd_pend;
  assign cpu.cpu_ready = cpu.cpu_we ? !w_full : w_rd_ok;
  assign w_push        = cpu.cpu_req && cpu.cpu_ready && cpu.cpu_we;
  assign w_rd_acc      = cpu.cpu_req && cpu.cpu_ready && !cpu.cpu_we;

  // Writes win over a pending read.
  assign w_pop      = (r_state == StIdle) && !w_empty && !i_fl_busy;
  assign w_start_rd = (r_state == StIdle) && w_empty && r_rd_pend && !i_fl_busy;
  assign w_done     = (r_state == StWaitDone) && !i_fl_busy;

  assign cpu.cpu_rvalid = r_rvalid;
  assign cpu.cpu_rdata  = r_rdata;
  assign o_fl_addr      = r_fl_addr;
  assign o_fl_din       = r_fl_din;

`ifdef READ_CACHE_EN
  logic              r_c_valid;
  logic [ADDR_W-1:0] r_c_addr;
  logic [7:0]        r_c_data;
  logic              r_rd_stale;
  logic              w_push_hits_rd;

  assign w_hit          = r_c_valid && (r_c_addr == cpu.cpu_addr);
  assign w_hit_data     = r_c_data;
  // A write to the in-flight read address makes the returned byte unsafe to cache.
  assign w_push_hits_rd = w_push && r_rd_pend && (cpu.cpu_addr == r_rd_addr);

  // Cache fill on read completion, invalidation on a matching posted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_valid  <= 1'b0;
      r_c_addr   <= '0;
      r_c_data   <= '0;
      r_rd_stale <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_rd_stale <= 1'b0;
      end else if (w_push_hits_rd) begin
        r_rd_stale <= 1'b1;
      end
      if (w_done && !r_op_wr && !r_rd_stale && !w_push_hits_rd) begin
        r_c_valid <= 1'b1;
        r_c_addr  <= r_rd_addr;
        r_c_data  <= i_fl_dout;
      end else if (w_push && (cpu.cpu_addr == r_c_addr)) begin
        r_c_valid <= 1'b0;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 8'h00;
`endif

  // Write buffer storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wbuf_addr[r_wr_ptr[WBUF_AW-1:0]] <= cpu.cpu_addr;
      r_wbuf_data[r_wr_ptr[WBUF_AW-1:0]] <= cpu.cpu_wdata;
    end
  end

  // Write buffer pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_pop || w_start_rd) w_state_next = StIssue;
      StIssue:    w_state_next = StWaitAck;
      StWaitAck:  if (i_fl_busy) w_state_next = StWaitDone;
      StWaitDone: if (!i_fl_busy) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // FSM outputs: one-cycle strobe while in ISSUE.
  always_comb begin
    o_fl_write = 1'b0;
    o_fl_read  = 1'b0;
    if (r_state == StIssue) begin
      o_fl_write = r_op_wr;
      o_fl_read  = !r_op_wr;
    end
  end

  // Operation latch, read tracking and CPU read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fl_addr <= '0;
      r_fl_din  <= '0;
      r_op_wr   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_pop) begin
        r_fl_addr <= r_wbuf_addr[r_rd_ptr[WBUF_AW-1:0]];
        r_fl_din  <= r_wbuf_data[r_rd_ptr[WBUF_AW-1:0]];
        r_op_wr   <= 1'b1;
      end else if (w_start_rd) begin
        r_fl_addr <= r_rd_addr;
        r_op_wr   <= 1'b0;
      end
      if (w_rd_acc && w_hit) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_hit_data;
      end else if (w_rd_acc) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= cpu.cpu_addr;
      end
      if (w_done && !r_op_wr) begin
        r_rd_pend <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= i_fl_dout;
      end
    end
  end
endmodule

// File: tb/tb_flash_host_bridge.sv
module tb_flash_host_bridge;
  localparam int unsigned AW = 16;
`ifdef READ_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flash_host_bridge_if #(.ADDR_W(AW)) cpu_if ();

  logic          fl_read, fl_write, fl_busy;
  logic [AW-1:0] fl_addr;
  logic [7:0]    fl_din, fl_dout;

  flash_host_bridge #(.WBUF_AW(2), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_if),
    .o_fl_read  (fl_read),
    .o_fl_write (fl_write),
    .o_fl_addr  (fl_addr),
    .o_fl_din   (fl_din),
    .i_fl_dout  (fl_dout),
    .i_fl_busy  (fl_busy)
  );

  typedef struct {bit wr; logic [15:0] addr; logic [7:0] data;} op_t;
  typedef struct {logic [7:0] data; bit hit; int acc_cyc;} rd_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int rd_seen = 0;
  op_t exp_op[$];
  rd_t exp_rd[$];
  logic [7:0] ref_mem [logic [15:0]];
  bit c_valid = 1'b0;
  logic [15:0] c_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Behavioural flash_ctl: busy rises fm_ack_dly cycles after a strobe, lasts fm_busy_len.
  int fm_ack_dly = 1;
  int fm_busy_len = 3;
  logic busy_hold = 1'b0;
  logic fm_busy, fm_active, fm_phase, fm_wr;
  int fm_cnt;
  logic [15:0] fm_addr;
  logic [7:0] fm_din;
  logic [7:0] fl_mem [logic [15:0]];
  assign fl_busy = fm_busy | busy_hold;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fm_busy <= 1'b0; fm_active <= 1'b0; fm_phase <= 1'b0; fm_wr <= 1'b0;
      fm_cnt <= 0; fm_addr <= '0; fm_din <= '0; fl_dout <= '0;
    end else if (!fm_active) begin
      if (fl_read || fl_write) begin
        fm_active <= 1'b1; fm_phase <= 1'b0; fm_cnt <= fm_ack_dly;
        fm_wr <= fl_write; fm_addr <= fl_addr; fm_din <= fl_din;
        if (fl_write) fl_mem[fl_addr] = fl_din;
      end
    end else if (!fm_phase) begin
      if (fm_cnt <= 1) begin fm_busy <= 1'b1; fm_phase <= 1'b1; fm_cnt <= fm_busy_len; end
      else fm_cnt <= fm_cnt - 1;
    end else begin
      if (fm_cnt <= 1) begin
        fm_busy <= 1'b0; fm_active <= 1'b0;
        if (!fm_wr) fl_dout <= fl_mem.exists(fm_addr) ? fl_mem[fm_addr] : dflt(fm_addr);
      end else fm_cnt <= fm_cnt - 1;
    end
  end

  // Monitor: strobes against expected flash ops, rvalid against expected read data.
  always @(negedge clk) begin
    if (!reset) begin
      if (fl_read || fl_write) begin
        op_t o;
        strobe_cnt++;
        chk("strobe_exclusive", {31'b0, fl_read && fl_write}, 0);
        chk("strobe_while_busy", {31'b0, fl_busy}, 0);
        chk("strobe_overlap", {31'b0, fm_active}, 0);
        if (exp_op.size() == 0) fail_now("unexpected_strobe");
        else begin
          o = exp_op.pop_front();
          chk("op_is_write", {31'b0, fl_write}, {31'b0, o.wr});
          chk("op_addr", {16'b0, fl_addr}, {16'b0, o.addr});
          if (o.wr) chk("op_din", {24'b0, fl_din}, {24'b0, o.data});
        end
      end
      if (fm_active) begin
        chk("addr_stable", {16'b0, fl_addr}, {16'b0, fm_addr});
        if (fm_wr) chk("din_stable", {24'b0, fl_din}, {24'b0, fm_din});
      end
      if (cpu_if.cpu_rvalid) begin
        rd_t r;
        rd_seen++;
        if (exp_rd.size() == 0) fail_now("unexpected_rvalid");
        else begin
          r = exp_rd.pop_front();
          chk("rdata", {24'b0, cpu_if.cpu_rdata}, {24'b0, r.data});
          if (r.hit) chk("hit_latency", cyc, r.acc_cyc + 1);
        end
      end
    end
  end

  // One CPU transfer: hold the request until accepted, record expectations at acceptance.
  task automatic cpu_xfer(input bit we, input logic [15:0] addr, input logic [7:0] data);
    int n = 0;
    bit ok = 0;
    @(negedge clk);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = we; cpu_if.cpu_addr = addr; cpu_if.cpu_wdata = data;
    while (n < 2000) begin
      #1;
      if (cpu_if.cpu_ready) begin
        op_t o;
        rd_t r;
        if (we) begin
          ref_mem[addr] = data;
          o.wr = 1'b1; o.addr = addr; o.data = data;
          exp_op.push_back(o);
          if (c_addr == addr) c_valid = 1'b0;
        end else begin
          r.hit = CacheEn && c_valid && (c_addr == addr);
          r.data = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
          r.acc_cyc = cyc;
          exp_rd.push_back(r);
          if (!r.hit) begin
            o.wr = 1'b0; o.addr = addr; o.data = 8'h00;
            exp_op.push_back(o);
          end
          c_valid = 1'b1; c_addr = addr;
        end
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    #1 cpu_if.cpu_req = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic cpu_read(input logic [15:0] addr);
    int target = rd_seen + 1;
    int n = 0;
    cpu_xfer(1'b0, addr, 8'h00);
    while (rd_seen < target && n < 1000) begin @(negedge clk); n++; end
    if (rd_seen < target) fail_now("rvalid_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_op.size() != 0 || exp_rd.size() != 0 || fm_active || fm_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) fail_now("idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] addr_tab [6] = '{16'h0010, 16'h0020, 16'h0123, 16'h8001, 16'hFFFF, 16'h0000};

  initial begin
    int s0;
    reset = 1'b1;
    cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = '0; cpu_if.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_fl_read", {31'b0, fl_read}, 0);
    chk("rst_fl_write", {31'b0, fl_write}, 0);
    chk("rst_fl_addr", {16'b0, fl_addr}, 0);
    chk("rst_rvalid", {31'b0, cpu_if.cpu_rvalid}, 0);
    chk("rst_ready", {31'b0, cpu_if.cpu_ready}, 1);
    reset = 1'b0;

    // Single write with a long busy window.
    fm_ack_dly = 1; fm_busy_len = 40;
    s0 = strobe_cnt;
    cpu_xfer(1'b1, 16'h0123, 8'hA5);
    wait_idle();
    chk("single_write_strobes", strobe_cnt - s0, 1);
    fm_busy_len = 3;

    // Fill the buffer while the flash is busy; the fifth write must stall.
    busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) cpu_xfer(1'b1, 16'h0200 + 16'(i), 8'h10 + 8'(i));
    @(negedge clk);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 16'h0204;
    #1 chk("ready_drops_when_full", {31'b0, cpu_if.cpu_ready}, 0);
    chk("no_strobe_while_held", strobe_cnt - s0, 1);
    cpu_if.cpu_req = 1'b0;
    busy_hold = 1'b0;
    cpu_xfer(1'b1, 16'h0204, 8'h14);
    wait_idle();
    chk("drain_strobes", strobe_cnt - s0, 6);

    // Read after write stalls until the write has completed.
    cpu_xfer(1'b1, 16'h0010, 8'h3C);
    @(negedge clk);
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 16'h0010;
    #1 chk("read_stalled", {31'b0, cpu_if.cpu_ready}, 0);
    cpu_if.cpu_req = 1'b0;
    cpu_read(16'h0010);
    wait_idle();

    // Repeated read, then a write invalidating it, then a read again.
    cpu_xfer(1'b1, 16'h0020, 8'h77);
    wait_idle();
    cpu_read(16'h0020);
    s0 = strobe_cnt;
    cpu_read(16'h0020);
    wait_idle();
    chk("repeat_read_strobes", strobe_cnt - s0, CacheEn ? 0 : 1);
    cpu_xfer(1'b1, 16'h0020, 8'h78);
    wait_idle();
    s0 = strobe_cnt;
    cpu_read(16'h0020);
    wait_idle();
    chk("read_after_inval_strobes", strobe_cnt - s0, 1);

    // Busy already high when the buffer becomes non-empty.
    busy_hold = 1'b1;
    s0 = strobe_cnt;
    cpu_xfer(1'b1, 16'h0300, 8'h5C);
    repeat (10) @(negedge clk);
    chk("no_strobe_busy_high", strobe_cnt - s0, 0);
    busy_hold = 1'b0;
    wait_idle();
    chk("one_strobe_after_busy", strobe_cnt - s0, 1);

    // Randomized mix of reads and writes with varying flash timing.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      fm_ack_dly = $urandom_range(1, 3);
      fm_busy_len = $urandom_range(1, 6);
      a = addr_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) < 4) cpu_read(a);
      else cpu_xfer(1'b1, a, 8'($urandom));
    end
    wait_idle();

    // Reset in the middle of a flash operation.
    fm_busy_len = 20;
    cpu_xfer(1'b1, 16'h0400, 8'hC3);
    begin
      int n = 0;
      while (!fm_busy && n < 100) begin @(negedge clk); n++; end
      if (!fm_busy) fail_now("busy_never_rose");
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_op.delete(); exp_rd.delete(); c_valid = 1'b0;
    cpu_if.cpu_we = 1'b0;
    #1;
    chk("mid_rst_fl_write", {31'b0, fl_write}, 0);
    chk("mid_rst_fl_addr", {16'b0, fl_addr}, 0);
    chk("mid_rst_fl_din", {24'b0, fl_din}, 0);
    chk("mid_rst_rdata", {24'b0, cpu_if.cpu_rdata}, 0);
    chk("mid_rst_ready", {31'b0, cpu_if.cpu_ready}, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    chk("no_strobe_after_rst", strobe_cnt - s0, 0);
    fm_busy_len = 3;
    cpu_read(16'h0400);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
